// File: rtl/data_sram_responder.sv
// Data-SRAM slave: answers req/addr_ok, data_ok/rdata from a word-addressed memory, responding in order.
// Latency: data_ok comes LATENCY cycles after address acceptance. Up to DEPTH transactions may be outstanding.
// Backpressure: addr_ok drops when the queue is full and nothing pops. resp_stall holds the queue head.
module data_sram_responder #(
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  input  logic        req_stall_i,
  input  logic        resp_stall_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Word storage; deliberately not reset, so contents survive resetn.
  logic [31:0] mem_q [2**MEM_AW];

  // Response queue: one slot per outstanding transaction.
  logic [DEPTH-1:0]       vld_q,  vld_d;
  logic [DEPTH-1:0]       wr_q,   wr_d;
  logic [DEPTH-1:0][31:0] data_q, data_d;
  logic [DEPTH-1:0][3:0]  cnt_q,  cnt_d;
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;

  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;
  logic              push;
  logic              pop;
  logic              unused_bits;

  // Size and the address bits outside the word index have no effect.
  assign unused_bits = ^{size_i, addr_i[31:MEM_AW+2], addr_i[1:0]};

  assign idx     = addr_i[MEM_AW+1:2];
  assign rd_word = mem_q[idx];

  assign pop       = data_ok_o;
  assign addr_ok_o = req_i & ~req_stall_i & ((count_q < CW'(DEPTH)) | pop);
  assign push      = req_i & addr_ok_o;

  assign data_ok_o = vld_q[head_q] & (cnt_q[head_q] == 4'd0) & ~resp_stall_i;
  // Writes carry zero data; the wr flag keeps rdata quiet for them regardless.
  assign rdata_o   = (data_ok_o & ~wr_q[head_q]) ? data_q[head_q] : 32'h0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Byte-enabled memory write at the acceptance edge.
  always_ff @(posedge clk_i) begin
    if (push && wr_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Queue next state: age all entries, retire the head, then append, so a full-queue push/pop reuses the slot.
  always_comb begin
    vld_d   = vld_q;
    wr_d    = wr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && cnt_q[i] != 4'd0) cnt_d[i] = cnt_q[i] - 1'b1;
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end
    if (push) begin
      vld_d[tail_q]  = 1'b1;
      wr_d[tail_q]   = wr_i;
      data_d[tail_q] = wr_i ? 32'h0 : rd_word;
      cnt_d[tail_q]  = 4'(LATENCY - 1);
      tail_d         = ptr_inc(tail_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset discards all pending responses.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vld_q   <= '0;
      wr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed scenarios plus randomized traffic.
// Instance A (LATENCY=2, DEPTH=2) is checked against a transaction-level model.
// Instance B (LATENCY=3, DEPTH=2) covers the full-queue addr_ok pattern.
module tb_data_sram_responder;

  localparam int LAT = 2;
  localparam int DEP = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        req = 0, wr = 0, req_stall = 0, resp_stall = 0;
  logic [1:0]  size = 0;
  logic [3:0]  wstrb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        aok, dok;
  logic [31:0] rdata;

  // Instance B signals
  logic        b_req = 0, b_wr = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        b_aok, b_dok;
  logic [31:0] b_rdata;

  data_sram_responder #(.MEM_AW(10), .LATENCY(LAT), .DEPTH(DEP)) u_dut_a (
    .clk_i(clk), .resetn_i(resetn), .req_i(req), .wr_i(wr), .size_i(size),
    .wstrb_i(wstrb), .addr_i(addr), .wdata_i(wdata), .addr_ok_o(aok),
    .data_ok_o(dok), .rdata_o(rdata), .req_stall_i(req_stall), .resp_stall_i(resp_stall));

  data_sram_responder #(.MEM_AW(10), .LATENCY(3), .DEPTH(2)) u_dut_b (
    .clk_i(clk), .resetn_i(resetn), .req_i(b_req), .wr_i(b_wr), .size_i(2'd2),
    .wstrb_i(4'hF), .addr_i(b_addr), .wdata_i(b_wdata), .addr_ok_o(b_aok),
    .data_ok_o(b_dok), .rdata_o(b_rdata), .req_stall_i(1'b0), .resp_stall_i(1'b0));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: memory image plus a queue of pending responses, each with
  // the absolute cycle number from which it may be delivered.
  typedef struct { int ready; logic [31:0] data; } pend_t;
  pend_t       m_q[$];
  logic [31:0] m_mem [0:1023];
  bit          m_known [0:1023];
  int          cyc = 0;
  logic        exp_aok, exp_dok;
  logic [31:0] exp_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_a(input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic rqs, input logic rss);
    req = r; wr = w; wstrb = s; addr = a; wdata = d;
    req_stall = rqs; resp_stall = rss; size = 2'($urandom);
  endtask

  task automatic model_eval();
    exp_dok   = (m_q.size() > 0) && (m_q[0].ready <= cyc) && !resp_stall;
    exp_rdata = exp_dok ? m_q[0].data : 32'h0;
    exp_aok   = req && !req_stall && ((m_q.size() < DEP) || exp_dok);
  endtask

  // Apply what happens at the coming edge to the model, then move to the next negedge.
  task automatic step_a();
    logic [9:0] i;
    if (exp_dok) void'(m_q.pop_front());
    if (req && exp_aok) begin
      i = addr[11:2];
      if (wr) begin
        for (int b = 0; b < 4; b++) if (wstrb[b]) m_mem[i][8*b +: 8] = wdata[8*b +: 8];
        m_known[i] = 1'b1;
        m_q.push_back('{cyc + LAT, 32'h0});
      end else begin
        m_q.push_back('{cyc + LAT, m_mem[i]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_assert++; if (aok !== 1'b0) begin n_fail++; $display("FAIL reset_aok: got %b expected 0", aok); end
    n_assert++; if (dok !== 1'b0) begin n_fail++; $display("FAIL reset_dok: got %b expected 0", dok); end
    n_assert++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_assert++; if (b_dok !== 1'b0 || b_aok !== 1'b0) begin n_fail++; $display("FAIL reset_b: got aok=%b dok=%b expected 0 0", b_aok, b_dok); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Shared shape for the short directed sequences on instance A: ops[t] = {valid, wr, wstrb, addr, wdata}.
  task automatic test_write_read();
    int dc[$]; logic [31:0] dv[$];
    for (int t = 0; t < 6; t++) begin
      if (t == 0)      drive_a(1, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0);
      else if (t == 1) drive_a(1, 0, 4'h0, 32'h100, $urandom, 0, 0);
      else             drive_a(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
      #1; model_eval();
      n_assert++; if (aok !== exp_aok) begin n_fail++; $display("FAIL wr_rd_aok t=%0d: got %b expected %b", t, aok, exp_aok); end
      n_assert++; if (dok !== exp_dok) begin n_fail++; $display("FAIL wr_rd_dok t=%0d: got %b expected %b", t, dok, exp_dok); end
      n_assert++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL wr_rd_rdata t=%0d: got %h expected %h", t, rdata, exp_rdata); end
      if (dok === 1'b1) begin dc.push_back(t); dv.push_back(rdata); end
      step_a();
    end
    n_assert++;
    if (dc.size() != 2) begin n_fail++; $display("FAIL wr_rd_pulses: got %0d expected 2", dc.size()); end
    else if (dc[0] != 2 || dc[1] != 3 || dv[0] !== 32'h0 || dv[1] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_rd_resp: got cycles %0d,%0d data %h,%h expected 2,3 00000000,deadbeef", dc[0], dc[1], dv[0], dv[1]);
    end
  endtask

  task automatic test_byte_strobes();
    int dc[$]; logic [31:0] dv[$];
    for (int t = 0; t < 7; t++) begin
      if (t == 0)      drive_a(1, 1, 4'hF, 32'h20, 32'h11223344, 0, 0);
      else if (t == 1) drive_a(1, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 0);
      else if (t == 2) drive_a(1, 0, 4'h0, 32'h23, 32'h0, 0, 0);
      else             drive_a(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
      #1; model_eval();
      n_assert++; if (aok !== exp_aok) begin n_fail++; $display("FAIL strb_aok t=%0d: got %b expected %b", t, aok, exp_aok); end
      n_assert++; if (dok !== exp_dok) begin n_fail++; $display("FAIL strb_dok t=%0d: got %b expected %b", t, dok, exp_dok); end
      n_assert++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL strb_rdata t=%0d: got %h expected %h", t, rdata, exp_rdata); end
      if (dok === 1'b1) begin dc.push_back(t); dv.push_back(rdata); end
      step_a();
    end
    n_assert++;
    if (dc.size() != 3) begin n_fail++; $display("FAIL strb_pulses: got %0d expected 3", dc.size()); end
    else if (dv[2] !== 32'h11BB33DD || dc[2] != 4) begin
      n_fail++; $display("FAIL strb_data: got %h at t=%0d expected 11bb33dd at t=4", dv[2], dc[2]);
    end
  endtask

  task automatic test_resp_stall();
    int dc[$]; logic [31:0] dv[$];
    for (int t = 0; t < 11; t++) begin
      if (t == 0)      drive_a(1, 0, 4'h0, 32'h100, 32'h0, 0, 0);
      else if (t == 1) drive_a(1, 0, 4'h0, 32'h20, 32'h0, 0, 0);
      else             drive_a(0, 0, 4'h0, 32'h0, 32'h0, 0, (t >= 2 && t <= 6));
      #1; model_eval();
      n_assert++; if (aok !== exp_aok) begin n_fail++; $display("FAIL stall_aok t=%0d: got %b expected %b", t, aok, exp_aok); end
      n_assert++; if (dok !== exp_dok) begin n_fail++; $display("FAIL stall_dok t=%0d: got %b expected %b", t, dok, exp_dok); end
      n_assert++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL stall_rdata t=%0d: got %h expected %h", t, rdata, exp_rdata); end
      if (dok === 1'b1) begin dc.push_back(t); dv.push_back(rdata); end
      step_a();
    end
    n_assert++;
    if (dc.size() != 2) begin n_fail++; $display("FAIL stall_pulses: got %0d expected 2", dc.size()); end
    else if (dc[0] != 7 || dc[1] != 8 || dv[0] !== 32'hDEADBEEF || dv[1] !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL stall_resp: got t=%0d,%0d data %h,%h expected 7,8 deadbeef,11bb33dd", dc[0], dc[1], dv[0], dv[1]);
    end
  endtask

  task automatic test_wrap();
    int dc[$]; logic [31:0] dv[$];
    for (int t = 0; t < 5; t++) begin
      if (t == 0)      drive_a(1, 1, 4'hF, 32'h1000, 32'h5A5A5A5A, 0, 0);
      else if (t == 1) drive_a(1, 0, 4'h0, 32'h0000, 32'h0, 0, 0);
      else             drive_a(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
      #1; model_eval();
      n_assert++; if (dok !== exp_dok) begin n_fail++; $display("FAIL wrap_dok t=%0d: got %b expected %b", t, dok, exp_dok); end
      if (dok === 1'b1) begin dc.push_back(t); dv.push_back(rdata); end
      step_a();
    end
    n_assert++;
    if (dc.size() != 2) begin n_fail++; $display("FAIL wrap_pulses: got %0d expected 2", dc.size()); end
    else if (dv[1] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL wrap_data: got %h expected 5a5a5a5a", dv[1]); end
  endtask

  task automatic test_reset_midflight();
    int dc[$]; logic [31:0] dv[$];
    drive_a(1, 0, 4'h0, 32'h100, 32'h0, 0, 0);
    #1; model_eval();
    n_assert++; if (aok !== 1'b1) begin n_fail++; $display("FAIL rst_mid_accept: got %b expected 1", aok); end
    step_a();
    drive_a(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    resetn = 1'b0;
    m_q.delete();
    #1;
    n_assert++; if (dok !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dok: got %b expected 0", dok); end
    n_assert++; if (u_dut_a.count_q !== '0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", u_dut_a.count_q); end
    @(posedge clk); #1;
    n_assert++; if (dok !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dok_edge: got %b expected 0", dok); end
    @(negedge clk);
    resetn = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (t == 3) drive_a(1, 0, 4'h0, 32'h20, 32'h0, 0, 0);
      else        drive_a(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
      #1; model_eval();
      n_assert++; if (dok !== exp_dok) begin n_fail++; $display("FAIL rst_mid_post_dok t=%0d: got %b expected %b", t, dok, exp_dok); end
      if (dok === 1'b1) begin dc.push_back(t); dv.push_back(rdata); end
      step_a();
    end
    n_assert++;
    if (dc.size() != 1) begin n_fail++; $display("FAIL rst_mid_pulses: got %0d expected 1", dc.size()); end
    else if (dc[0] != 3 + LAT || dv[0] !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL rst_mid_resp: got t=%0d data %h expected t=%0d data 11bb33dd", dc[0], dv[0], 3 + LAT);
    end
  endtask

  task automatic test_random();
    logic hold = 1'b0, act = 1'b0, r_w = 1'b0;
    logic [3:0]  r_s = '0;
    logic [31:0] r_a = '0, r_d = '0;
    logic [9:0]  i;
    for (int t = 0; t < 410; t++) begin
      if (!hold) begin
        i   = 10'h200 + 10'($urandom_range(0, 15));
        r_w = !m_known[i] || ($urandom_range(0, 1) == 1);
        r_s = m_known[i] ? 4'($urandom) : 4'hF;
        r_a = {20'($urandom), i, 2'($urandom)};
        r_d = $urandom;
        act = (t < 400) && ($urandom_range(0, 3) != 0);
      end
      drive_a(act, r_w, r_s, r_a, r_d, (t < 400) && ($urandom_range(0, 4) == 0),
              (t < 400) && ($urandom_range(0, 3) == 0));
      #1; model_eval();
      n_assert++; if (aok !== exp_aok) begin n_fail++; $display("FAIL rand_aok t=%0d: got %b expected %b", t, aok, exp_aok); end
      n_assert++; if (dok !== exp_dok) begin n_fail++; $display("FAIL rand_dok t=%0d: got %b expected %b", t, dok, exp_dok); end
      n_assert++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata t=%0d: got %h expected %h", t, rdata, exp_rdata); end
      hold = act && (aok !== 1'b1);
      step_a();
    end
  endtask

  task automatic test_full_queue();
    logic [31:0] wv[4];
    bit          pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int          exp_dc[4] = '{3, 4, 6, 7};
    int          dc[$]; logic [31:0] dv[$];
    int          acc = 0;
    for (int k = 0; k < 4; k++) begin
      wv[k] = $urandom;
      b_req = 1'b1; b_wr = 1'b1; b_addr = 32'h40 + 32'(k * 4); b_wdata = wv[k];
      #1;
      n_assert++; if (b_aok !== 1'b1) begin n_fail++; $display("FAIL fq_wr_aok k=%0d: got %b expected 1", k, b_aok); end
      @(negedge clk);
      b_req = 1'b0;
      repeat (4) @(negedge clk);
    end
    b_wr = 1'b0;
    for (int t = 0; t < 12; t++) begin
      b_req  = (acc < 4);
      b_addr = 32'h40 + 32'(acc * 4);
      #1;
      if (t < 5) begin
        n_assert++; if (b_aok !== pat[t]) begin n_fail++; $display("FAIL fq_aok t=%0d: got %b expected %b", t, b_aok, pat[t]); end
      end
      if (b_dok === 1'b1) begin dc.push_back(t); dv.push_back(b_rdata); end
      if (b_req && b_aok === 1'b1) acc++;
      @(negedge clk);
    end
    b_req = 1'b0;
    n_assert++;
    if (dc.size() != 4) begin n_fail++; $display("FAIL fq_pulses: got %0d expected 4", dc.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_assert++;
        if (dc[k] != exp_dc[k] || dv[k] !== wv[k]) begin
          n_fail++; $display("FAIL fq_resp k=%0d: got t=%0d data %h expected t=%0d data %h", k, dc[k], dv[k], exp_dc[k], wv[k]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_resp_stall();
    test_wrap();
    test_reset_midflight();
    test_random();
    test_full_queue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

SRAM-like slave that answers the CPU's data-SRAM request/response handshake (`req`/`addr_ok` address phase, `data_ok`/`rdata` data phase) from an internal word-addressed memory. It responds in order with a parameterised fixed latency, holds up to `DEPTH` outstanding transactions, and exposes stall inputs. This lets the memory stage's `data_ok` wait path be exercised and the block serve as the data side of the SoC-lite memory model.

## Interface
- `MEM_AW`, 10, log2 of memory size in 32-bit words.
- `LATENCY`, 2, cycles from address acceptance to `data_ok`; legal range 1..15.
- `DEPTH`, 2, maximum outstanding transactions (response queue entries); legal range 1..4.

- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid, held by the master until `addr_ok`.
- `wr`  in  1  1 = write, 0 = read.
- `size`  in  2  access size; informational only, ignored by the block.
- `wstrb`  in  4  byte enables for writes.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data.
- `addr_ok`  out  1  address phase accepted this cycle (combinational).
- `data_ok`  out  1  response valid this cycle; one-cycle pulse per transaction.
- `rdata`  out  32  read data, valid with `data_ok`.
- `req_stall`  in  1  test hook: forces `addr_ok` low.
- `resp_stall`  in  1  test hook: forces `data_ok` low and holds the queue head.

## Operation
- Word index is `addr[MEM_AW+1:2]`. Upper bits and `addr[1:0]` are ignored, so addresses wrap modulo the memory size.
- `addr_ok = req & ~req_stall & (count < DEPTH | pop)`, where `pop = data_ok`. A simultaneous push and pop is allowed when the queue is full.
- Accept (`req & addr_ok` at an edge):
  - Write: memory bytes with `wstrb[i]=1` are updated at that edge. The entry is queued with `rdata` = 0.
  - Read: the memory word is sampled at that edge, before any write accepted at the same edge (none is possible, since there is one port). The value is stored in the entry. A read issued after a write to the same word returns the new data.
- Each queue entry holds {valid, wr, data[31:0], cnt[3:0]}. `cnt` is loaded with `LATENCY-1` on push. Every valid entry's `cnt` decrements each cycle, saturating at 0, including while `resp_stall` is high.
- `data_ok = head.valid & head.cnt==0 & ~resp_stall`. `rdata = head.data` when `data_ok` is high, otherwise 0.
- Pop on `data_ok`. Responses are strictly in acceptance order. Writes also produce `data_ok`.
- The queue is a circular buffer with head/tail pointers and `count` (0..DEPTH). Pointers wrap at `DEPTH`.
- `size` has no effect. Byte/halfword extraction and sign extension are done by the requester from the full 32-bit word.
- Memory array is not reset; contents are X until written.

## Timing
- Reset values: `addr_ok`=0 (`req` low at reset), `data_ok`=0, `rdata`=0. Queue is empty, `count`=0, pointers 0.
- Accepting at edge E gives `data_ok` high in the cycle after E+(LATENCY-1) edges. With `LATENCY`=1, `data_ok` is high in the cycle immediately following acceptance.
- Back-to-back accepts yield back-to-back `data_ok` pulses at the same spacing.
- Sustained throughput is 1 transaction/cycle iff `DEPTH >= LATENCY`. Otherwise `addr_ok` drops when the queue is full and no pop occurs.
- `resp_stall` delays the head. When it releases, queued entries whose `cnt` is already 0 respond on consecutive cycles.
- `resetn` low mid-transaction: queue is cleared immediately and asynchronously, and pending responses are discarded (no `data_ok`). Memory writes already accepted persist.
- `addr_ok` has a combinational path from `req`, `req_stall`, `resp_stall` and queue state. `data_ok`/`rdata` depend only on registers and `resp_stall`.

## Test plan
- Write then read, `LATENCY`=2: write 0xDEADBEEF to 0x100 with `wstrb`=F, then read 0x100. Both are accepted on consecutive cycles. `data_ok` pulses 2 cycles after each accept, and the second has `rdata`=0xDEADBEEF.
- Byte strobes: write 0x11223344 to 0x20 with F, then 0xAABBCCDD with `wstrb`=0101, then read 0x23. `rdata`=0x11BB33DD.
- Full queue, `DEPTH`=2, `LATENCY`=3: hold `req` for 4 reads. `addr_ok` pattern is 1,1,0,1,1. Four `data_ok` pulses arrive in order.
- `resp_stall` high for 5 cycles with 2 reads pending: no `data_ok` during the stall. After release, `data_ok` is high on two consecutive cycles with correct data in order.
- Wrap-around: with `MEM_AW`=10, write 0x5A5A5A5A to 0x1000, then read 0x0000. `rdata`=0x5A5A5A5A.
- Reset mid-flight: accept a read, then drop `resetn` for 1 cycle before `data_ok`. No `data_ok` follows, and `count`=0. A new read then responds normally after `LATENCY`.
